// File: rtl/truth_table_sweep_checker.sv
// Clocked truth-table sweep checker: walks a 4-input combinational circuit through
// every input pattern, captures F after a settle time and compares it against a latched table.
module truth_table_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   f,
  output logic [N_IN-1:0]        abcd,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   cap_table,  // "table" is a reserved word
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_err
);

  localparam int N_PAT = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  PAT_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_r, next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [N_PAT-1:0]   exp_r;
  logic [N_PAT-1:0]   table_r;
  logic [N_IN-1:0]    abcd_r;
  logic [N_IN-1:0]    first_err_r;
  logic [N_IN:0]      err_count_r;
  logic               pass_r, busy_r, done_r;
  logic               busy_s, done_s;
  logic               sample_s, mismatch_s, last_s;

  assign sample_s   = (state_r == APPLY) && (cnt_r == CNT_LAST);
  assign mismatch_s = sample_s && (f != exp_r[abcd_r]);
  assign last_s     = sample_s && (abcd_r == PAT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = APPLY;
        else       next_state_s = IDLE;
      end
      APPLY: begin
        if (last_s) next_state_s = FINISH;
        else        next_state_s = APPLY;
      end
      FINISH:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Status outputs are decoded from the upcoming state so they register cleanly
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (next_state_s)
      APPLY:   busy_s = 1'b1;
      FINISH:  done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Status output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Pattern stepping, capture and compare datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= '0;
      exp_r       <= '0;
      table_r     <= '0;
      abcd_r      <= '0;
      first_err_r <= '0;
      err_count_r <= '0;
      pass_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          abcd_r <= '0;
          if (start) begin
            exp_r       <= expected;
            table_r     <= '0;
            err_count_r <= '0;
            first_err_r <= '0;
            pass_r      <= 1'b0;
            cnt_r       <= '0;
          end
        end
        APPLY: begin
          if (sample_s) begin
            table_r[abcd_r] <= f;
            cnt_r           <= '0;
            if (mismatch_s) begin
              err_count_r <= err_count_r + (N_IN+1)'(1);
              if (err_count_r == '0) first_err_r <= abcd_r;
            end
            // pass must include the final sample taken on this same edge
            if (last_s) begin
              abcd_r <= '0;
              pass_r <= (err_count_r == '0) && !mismatch_s;
            end else begin
              abcd_r <= abcd_r + N_IN'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FINISH: begin
          abcd_r <= '0;
          cnt_r  <= '0;
        end
        default: begin
          abcd_r <= '0;
          cnt_r  <= '0;
        end
      endcase
    end
  end

  assign abcd      = abcd_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign cap_table = table_r;
  assign err_count = err_count_r;
  assign first_err = first_err_r;

endmodule
